// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory access path: access sizes,
// access-sequencer states and the default downstream memory depth.
package mips_mem_pkg;

  localparam int unsigned DEPTH_DEFAULT = 32'd200;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_RD     = 3'd2,
    ST_WR     = 3'd3,
    ST_RMW_RD = 3'd4,
    ST_RMW_WR = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Big-endian lane selection: extracts and extends a sub-word from a memory
// word, and reports which bits that lane occupies (used for store merging).
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result,
  output logic [31:0] lane_mask
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] byte_mask_s;

  // byte and halfword lane pick, offset 0 is the most significant lane
  always_comb begin
    byte_s      = 8'h00;
    byte_mask_s = 32'h0000_0000;
    case (offset)
      2'd0: begin byte_s = word[31:24]; byte_mask_s = 32'hFF00_0000; end
      2'd1: begin byte_s = word[23:16]; byte_mask_s = 32'h00FF_0000; end
      2'd2: begin byte_s = word[15:8];  byte_mask_s = 32'h0000_FF00; end
      2'd3: begin byte_s = word[7:0];   byte_mask_s = 32'h0000_00FF; end
      default: begin byte_s = 8'h00; byte_mask_s = 32'h0000_0000; end
    endcase
    if (offset[1]) begin
      half_s = word[15:0];
    end else begin
      half_s = word[31:16];
    end
  end

  // extension and lane mask by access size
  always_comb begin
    result    = word;
    lane_mask = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        result    = sign_ext ? {{24{byte_s[7]}}, byte_s} : {24'h00_0000, byte_s};
        lane_mask = byte_mask_s;
      end
      SZ_HALF: begin
        result    = sign_ext ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
        lane_mask = offset[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      end
      SZ_WORD: begin
        result    = word;
        lane_mask = 32'hFFFF_FFFF;
      end
      default: begin
        result    = word;
        lane_mask = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sequencer between byte-addressed MIPS loads/stores and a word-indexed data
// memory: range/alignment check, sub-word load extension, read-modify-write stores.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] MemData
);

  state_t      state_r, state_n_s;
  logic        err_n_s;
  logic        accept_s;
  logic        bad_s;

  logic        we_r;
  logic [1:0]  size_r;
  logic        sext_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  logic        busy_r, done_r, err_r, mem_read_r, mem_write_r;
  logic [31:0] address_r, write_data_r, rdata_r;

  logic [31:0] align_result_s, lane_mask_s, placed_s, merge_s;

  assign accept_s = (state_r == ST_IDLE) && req;
  assign bad_s    = (size_r == SZ_BAD) || is_misaligned(size_r, addr_r[1:0]) ||
                    ({2'b00, addr_r[31:2]} >= 32'(DEPTH));

  load_align u_align (
    .word      (MemData),
    .offset    (addr_r[1:0]),
    .size      (size_r),
    .sign_ext  (sext_r),
    .result    (align_result_s),
    .lane_mask (lane_mask_s)
  );

  // store data replicated into every lane, then masked into the read word
  assign placed_s = (size_r == SZ_BYTE) ? {4{wdata_r[7:0]}} : {2{wdata_r[15:0]}};
  assign merge_s  = (MemData & ~lane_mask_s) | (placed_s & lane_mask_s);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // next-state and error decision
  always_comb begin
    state_n_s = state_r;
    err_n_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_n_s = ST_CHECK;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (bad_s) begin
          state_n_s = ST_DONE;
          err_n_s   = 1'b1;
        end else if (!we_r) begin
          state_n_s = ST_RD;
        end else if (size_r == SZ_WORD) begin
          state_n_s = ST_WR;
        end else begin
          state_n_s = ST_RMW_RD;
        end
      end
      ST_RD:     state_n_s = ST_DONE;
      ST_WR:     state_n_s = ST_DONE;
      ST_RMW_RD: state_n_s = ST_RMW_WR;
      ST_RMW_WR: state_n_s = ST_DONE;
      ST_DONE:   state_n_s = ST_IDLE;
      default:   state_n_s = ST_IDLE;
    endcase
  end

  // request capture; inputs are ignored for the rest of the access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      size_r  <= SZ_BYTE;
      sext_r  <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      we_r    <= we;
      size_r  <= size;
      sext_r  <= sign_ext;
      addr_r  <= addr;
      wdata_r <= wdata;
    end
  end

  // registered outputs, derived from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      address_r    <= 32'h0000_0000;
      write_data_r <= 32'h0000_0000;
      rdata_r      <= 32'h0000_0000;
    end else begin
      busy_r      <= (state_n_s != ST_IDLE);
      done_r      <= (state_n_s == ST_DONE);
      err_r       <= err_n_s;
      mem_read_r  <= (state_n_s == ST_RD) || (state_n_s == ST_RMW_RD);
      mem_write_r <= (state_n_s == ST_WR) || (state_n_s == ST_RMW_WR);
      if (accept_s) begin
        address_r <= {2'b00, addr[31:2]};
      end
      if (state_n_s == ST_WR) begin
        write_data_r <= wdata_r;
      end else if (state_n_s == ST_RMW_WR) begin
        write_data_r <= merge_s;
      end
      if (state_r == ST_RD) begin
        rdata_r <= align_result_s;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign MemRead   = mem_read_r;
  assign MemWrite  = mem_write_r;
  assign Address   = address_r;
  assign WriteData = write_data_r;
  assign rdata     = rdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit with a 200-word memory model.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        MemRead, MemWrite;
  logic [31:0] Address, WriteData, MemData;

  logic [31:0] mem [0:199] = '{default: 32'h0000_0000};
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_val;

  int n_chk;
  int n_fail;
  int both_cnt;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [18];

  mem_access_unit #(.DEPTH(200)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .rdata(rdata), .MemRead(MemRead),
    .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
    .MemData(MemData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign MemData = (Address < 32'd200) ? mem[Address[7:0]] : 32'h0000_0000;

  always @(posedge clk) begin
    if (MemWrite && (Address < 32'd200)) mem[Address[7:0]] <= WriteData;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end

  always @(negedge clk) begin
    if (MemRead && MemWrite) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_access(input vec_t v, output int lat, output int mr, output int mw,
                            output logic [31:0] wr_addr);
    wait_idle();
    req = 1'b1; we = v.we; size = v.size; sign_ext = v.sext; addr = v.addr; wdata = v.wdata;
    lat = 0; mr = 0; mw = 0; wr_addr = 32'hFFFF_FFFF;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        req = 1'b0; we = ~we; size = ~size; sign_ext = ~sign_ext;
        addr = 32'h0000_0000; wdata = 32'h0000_0000;
      end
      if (MemRead) mr++;
      if (MemWrite) begin
        mw++;
        wr_addr = Address;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, mr, mw, exp_mr, exp_mw, low_run, dones, mr_acc, mw_acc;
    logic [31:0] wr_addr;
    n_chk = 0; n_fail = 0; both_cnt = 0;
    poke_en = 1'b0; poke_idx = 8'd0; poke_val = 32'h0000_0000;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = SZ_WORD; sign_ext = 1'b0;
    addr = 32'h0000_0000; wdata = 32'h0000_0000;

    vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h0C,  32'hDEADBEEF, 1'b0, 3, 32'h00000000, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h0C,  32'h00000000, 1'b0, 3, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, SZ_BYTE, 1'b0, 32'h0D,  32'hFFFFFF11, 1'b0, 4, 32'hDEADBEEF, 32'hDE11BEEF};
    vecs[3]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0E,  32'h00000000, 1'b0, 3, 32'hFFFFFFBE, 32'h0};
    vecs[4]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0E,  32'h00000000, 1'b0, 3, 32'h000000BE, 32'h0};
    vecs[5]  = '{1'b1, SZ_HALF, 1'b0, 32'h0E,  32'hAAAA8001, 1'b0, 4, 32'h000000BE, 32'hDE118001};
    vecs[6]  = '{1'b0, SZ_HALF, 1'b1, 32'h0E,  32'h00000000, 1'b0, 3, 32'hFFFF8001, 32'h0};
    vecs[7]  = '{1'b0, SZ_HALF, 1'b0, 32'h0E,  32'h00000000, 1'b0, 3, 32'h00008001, 32'h0};
    vecs[8]  = '{1'b0, SZ_WORD, 1'b0, 32'h0D,  32'h00000000, 1'b1, 2, 32'h00008001, 32'h0};
    vecs[9]  = '{1'b0, SZ_HALF, 1'b1, 32'h03,  32'h00000000, 1'b1, 2, 32'h00008001, 32'h0};
    vecs[10] = '{1'b0, SZ_WORD, 1'b0, 32'h320, 32'h00000000, 1'b1, 2, 32'h00008001, 32'h0};
    vecs[11] = '{1'b0, SZ_BYTE, 1'b1, 32'h0C,  32'h00000000, 1'b0, 3, 32'hFFFFFFDE, 32'h0};
    vecs[12] = '{1'b0, SZ_BAD,  1'b0, 32'h0C,  32'h00000000, 1'b1, 2, 32'hFFFFFFDE, 32'h0};
    vecs[13] = '{1'b1, SZ_BYTE, 1'b0, 32'h31C, 32'h000000AB, 1'b0, 4, 32'hFFFFFFDE, 32'hAB000000};
    vecs[14] = '{1'b0, SZ_WORD, 1'b0, 32'h31C, 32'h00000000, 1'b0, 3, 32'hAB000000, 32'h0};
    vecs[15] = '{1'b0, SZ_HALF, 1'b0, 32'h0F,  32'h00000000, 1'b1, 2, 32'hAB000000, 32'h0};
    vecs[16] = '{1'b0, SZ_BYTE, 1'b1, 32'h0F,  32'h00000000, 1'b0, 3, 32'h00000001, 32'h0};
    vecs[17] = '{1'b1, SZ_HALF, 1'b0, 32'h11,  32'h00001234, 1'b1, 2, 32'h00000001, 32'h0};

    // reset values
    #12;
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_err", err, 32'd0);
    chk("rst_memread", MemRead, 32'd0);
    chk("rst_memwrite", MemWrite, 32'd0);
    chk("rst_address", Address, 32'd0);
    chk("rst_writedata", WriteData, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_access(vecs[i], lat, mr, mw, wr_addr);
      exp_mr = (!vecs[i].exp_err && (!vecs[i].we || vecs[i].size != SZ_WORD)) ? 1 : 0;
      exp_mw = (!vecs[i].exp_err && vecs[i].we) ? 1 : 0;
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_err", i), err, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_memread_cycles", i), mr, exp_mr);
      chk($sformatf("v%0d_memwrite_cycles", i), mw, exp_mw);
      if (exp_mw == 1) begin
        chk($sformatf("v%0d_write_index", i), wr_addr, {2'b00, vecs[i].addr[31:2]});
        chk($sformatf("v%0d_mem_word", i), mem[vecs[i].addr[9:2]], vecs[i].exp_mem);
      end
    end

    // reset during the read half of a sub-word store
    wait_idle();
    poke_en = 1'b1; poke_idx = 8'd4; poke_val = 32'h12345678;
    @(negedge clk); poke_en = 1'b0;
    req = 1'b1; we = 1'b1; size = SZ_BYTE; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h55;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    chk("rmw_rd_memread", MemRead, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 32'd0);
    chk("midrst_memread", MemRead, 32'd0);
    chk("midrst_memwrite", MemWrite, 32'd0);
    chk("midrst_address", Address, 32'd0);
    chk("midrst_writedata", WriteData, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    mw = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (MemWrite) mw++;
      if (k == 1) rst_n = 1'b1;
    end
    chk("midrst_no_write", mw, 32'd0);
    chk("midrst_mem4", mem[4], 32'h12345678);
    chk("midrst_idle", busy, 32'd0);

    // req held high with alternating SW/LW
    wait_idle();
    req = 1'b1; we = 1'b1; size = SZ_WORD; sign_ext = 1'b0; addr = 32'h40; wdata = 32'hCAFEF00D;
    low_run = 0; dones = 0; mr_acc = 0; mw_acc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (MemRead) mr_acc++;
      if (MemWrite) mw_acc++;
      if (!busy) begin
        low_run++;
      end else if (low_run > 0) begin
        chk("held_busy_gap", low_run, 32'd1);
        low_run = 0;
      end
      if (done) begin
        chk("held_memread_cycles", mr_acc, {31'd0, ~we});
        chk("held_memwrite_cycles", mw_acc, {31'd0, we});
        if (!we) chk("held_lw_rdata", rdata, 32'hCAFEF00D);
        we = ~we;
        mr_acc = 0; mw_acc = 0;
        dones++;
      end
    end
    req = 1'b0;
    chk("held_done_count", dones, 32'd10);
    chk("held_mem16", mem[16], 32'hCAFEF00D);

    @(negedge clk);
    chk("never_read_and_write", both_cnt, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequential bridge between the multicycle MIPS datapath (byte addresses, LB/LBU/LH/LHU/LW/SB/SH/SW) and the word-indexed, 200-entry data Memory block.
- Converts byte addresses to word indices and sequences read-modify-write for sub-word stores.
- Extracts and sign/zero-extends sub-word loads into a registered read-data (MDR-style) output.
- Reports misaligned and out-of-range accesses with a req/done handshake.

Parameters:
DEPTH, 200, number of 32-bit words in the downstream Memory; word indices 0..DEPTH-1 are valid.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  1  access request; sampled only in IDLE.
we  input  1  1 = store, 0 = load; sampled with req.
size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal (treated as error).
sign_ext  input  1  1 = sign-extend sub-word load, 0 = zero-extend.
addr  input  32  byte address.
wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
busy  output  1  high while not in IDLE.
done  output  1  one-cycle pulse when access completes (with or without error).
err  output  1  valid with done: misaligned, out-of-range or size==3.
rdata  output  32  load result, held until next load completes.
MemRead  output  1  to Memory.
MemWrite  output  1  to Memory.
Address  output  32  word index = addr[31:2] (zero-extended).
WriteData  output  32  to Memory.
MemData  input  32  from Memory (combinational read).

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy, done, err, MemRead, MemWrite = 0; Address, WriteData, rdata = 0. Reset mid-operation aborts immediately; no MemWrite is ever issued after rst_n falls.
- On req in IDLE, latch we, size, sign_ext, addr, wdata. Later input changes are ignored until the next IDLE.
- Byte lanes are big-endian:
  - Byte offset 0 occupies [31:24], offset 3 occupies [7:0].
  - Halfword offset 0 occupies [31:16], offset 2 occupies [15:0].
- Error check happens in the cycle after acceptance (CHECK state). Error conditions:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - size==3;
  - addr[31:2] >= DEPTH.
- On error: go to DONE with err=1. No MemRead/MemWrite is asserted and rdata is unchanged.
- States: IDLE -> CHECK -> {RD, WR, RMW_RD} -> ... -> DONE -> IDLE.
  - Load: RD drives MemRead=1 and Address; MemData is captured at the clock edge; extract/extend into rdata.
  - Word store: WR drives MemWrite=1 for exactly one cycle with WriteData=wdata.
  - Sub-word store: RMW_RD (MemRead=1, latch MemData) -> RMW_WR (MemWrite=1, WriteData = latched word with target lane replaced by wdata[7:0] or wdata[15:0]).
  - DONE: done=1 for one cycle; err holds its value during that cycle. Return to IDLE.
- Latency from req cycle to done cycle:
  - load = 3;
  - word store = 3;
  - sub-word store = 4;
  - error = 2.
- MemRead and MemWrite are registered and never high together. Both are 0 in IDLE, CHECK and DONE.
- Address is held stable for the whole access, including the cycle MemWrite falls.
- req asserted while busy is ignored; no queueing. req held high in DONE is not accepted until IDLE, giving a 1-cycle gap minimum.
- Extension rules:
  - byte: sign_ext ? {{24{b[7]}},b} : {24'b0,b};
  - half: same rule with 16 bits;
  - word: sign_ext is ignored.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum constants;
  - DEPTH default.
- One natural sub-module: load_align (combinational; word, offset, size, sign_ext -> extended result). It is reused by the store-merge path as lane-select logic.

Test Plan:
- Reset mid-RMW: assert rst_n=0 during RMW_RD of SB to addr 0x10 -> all outputs 0, MemWrite never pulses, Memory word 4 unchanged.
- SW addr 0x0C wdata 0xDEADBEEF, then LW addr 0x0C -> MemWrite pulse with Address=3; done 3 cycles after req; rdata=0xDEADBEEF, err=0.
- Word 3 = 0xDEADBEEF, SB addr 0x0D wdata 0x11 -> word 3 = 0xDE11BEEF. Then LB addr 0x0E sign_ext=1 -> rdata=0xFFFFFFBE; LBU -> 0x000000BE.
- SH addr 0x0E wdata 0x8001, then LH addr 0x0E sign_ext=1 -> rdata=0xFFFF8001; LHU -> 0x00008001; done 4 cycles after SH req.
- LW addr 0x0D; LH addr 0x03; LW addr 0x320 (index 200) -> each gives done with err=1 two cycles after req, no MemRead/MemWrite, rdata unchanged.
- Hold req=1 continuously with alternating SW/LW -> exactly one access per done, MemRead and MemWrite never simultaneous, busy low exactly one cycle between accesses.
